arp_engine: RTL and testbench



---
 rtl/arp_engine.sv | 212 +++++++++++++++++++++
 tb/tb_arp_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_engine.sv
// arp_engine: ARP responder and gratuitous announcer for NUM_IP local IPv4 slots behind one MAC
module arp_engine #(
  parameter int NUM_IP          = 4,
  parameter int ANNOUNCE_PERIOD = 0,
  parameter int CNT_W           = 16,
  parameter int FRAME_LEN       = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [47:0]          my_hwaddr,
  input  logic [32*NUM_IP-1:0] my_ip,
  input  logic [NUM_IP-1:0]    ip_en,
  input  logic                 announce_req,
  input  logic                 rx_vld,
  input  logic                 rx_last,
  input  logic                 rx_err,
  input  logic                 rx_crc_ok,
  input  logic                 rx_busy,
  input  logic [10:0]          rx_addr,
  input  logic [7:0]           rx_data,
  output logic                 tx_req,
  output logic [10:0]          tx_count,
  input  logic                 tx_grant,
  input  logic [10:0]          tx_addr,
  input  logic                 tx_adv,
  input  logic                 tx_last,
  output logic [7:0]           tx_data,
  output logic                 count_arp,
  output logic [CNT_W-1:0]     stat_rx_req,
  output logic [CNT_W-1:0]     stat_tx_reply,
  output logic [CNT_W-1:0]     stat_tx_ann
);
  localparam int IW = NUM_IP > 1 ? $clog2(NUM_IP) : 1;
  localparam int TW = ANNOUNCE_PERIOD > 1 ? $clog2(ANNOUNCE_PERIOD) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(ANNOUNCE_PERIOD > 0 ? ANNOUNCE_PERIOD - 1 : 0);
  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_CHECK = 4'b0010;
  localparam logic [3:0] S_ARB   = 4'b0100;
  localparam logic [3:0] S_SEND  = 4'b1000;

  logic [3:0]        state_q, state_d;
  logic              rep_q, rep_d, hdr_ok_q, hdr_ok_d, err_q, err_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_IP-1:0] match_q, match_d, pend_q, pend_d, ip_en_q, busy_mask;
  logic [47:0]       smac_q, smac_d, mac_sh_q, mac_sh_d;
  logic [31:0]       sip_q, sip_d, ip_sh_q, ip_sh_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              count_arp_q, count_arp_d, load, hdr_bad, tmr_exp;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d, rep_cnt_q, rep_cnt_d, ann_cnt_q, ann_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  int                rx_a;

  function automatic logic [7:0] byte_of(input logic [47:0] v, input int n, input int i);
    return 8'(v >> (8 * (n - 1 - i)));
  endfunction

  function automatic logic [7:0] hdr_byte(input int i, input logic rep);
    logic [79:0] h;
    h = {72'h080600010800060400, rep ? 8'h02 : 8'h01};
    return 8'(h >> (8 * (9 - i)));
  endfunction

  function automatic logic [7:0] tx_byte(input int a, input logic rep, input logic [47:0] mac,
                                         input logic [31:0] ip, input logic [47:0] smac,
                                         input logic [31:0] sip);
    if (a < 6)  return rep ? byte_of(smac, 6, a) : 8'hFF;
    if (a < 12) return byte_of(mac, 6, a - 6);
    if (a < 22) return hdr_byte(a - 12, rep);
    if (a < 28) return byte_of(mac, 6, a - 22);
    if (a < 32) return byte_of({16'h0, ip}, 4, a - 28);
    if (a < 38) return rep ? byte_of(smac, 6, a - 32) : 8'h00;
    if (a < 42) return byte_of({16'h0, rep ? sip : ip}, 4, a - 38);
    return 8'h00;
  endfunction

  function automatic logic [IW-1:0] lowest(input logic [NUM_IP-1:0] v);
    lowest = '0;
    for (int k = NUM_IP - 1; k >= 0; k--) if (v[k]) lowest = IW'(k);
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction

  assign rx_a = int'(rx_addr);
  assign hdr_bad = (rx_a < 6 && rx_data != 8'hFF && rx_data != byte_of(my_hwaddr, 6, rx_a)) ||
                   ((rx_a == 12 || rx_a == 13 || rx_a == 16 || rx_a == 17 || rx_a == 20 || rx_a == 21) &&
                    rx_data != hdr_byte(rx_a - 12, 1'b0));
  assign busy_mask = (state_q == S_ARB || state_q == S_SEND) ? NUM_IP'(1) << idx_q : '0;
  assign tmr_exp = ANNOUNCE_PERIOD != 0 && timer_q == T_MAX;
  assign timer_d = (ANNOUNCE_PERIOD == 0 || tmr_exp) ? '0 : timer_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rep_d       = rep_q;
    idx_d       = idx_q;
    hdr_ok_d    = hdr_ok_q;
    err_d       = err_q;
    match_d     = match_q;
    smac_d      = smac_q;
    sip_d       = sip_q;
    mac_sh_d    = mac_sh_q;
    ip_sh_d     = ip_sh_q;
    tx_data_d   = 8'h00;
    count_arp_d = 1'b0;
    rx_cnt_d    = rx_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    ann_cnt_d   = ann_cnt_q;
    load        = 1'b0;
    pend_d      = pend_q & ~(ip_en_q & ~ip_en & ~busy_mask);
    if (state_q == S_IDLE) begin
      hdr_ok_d = 1'b1;
      err_d    = 1'b0;
      match_d  = '0;
      if (rx_busy) state_d = S_CHECK;
      else if (|pend_q) begin
        state_d = S_ARB;
        rep_d   = 1'b0;
        idx_d   = lowest(pend_q);
        load    = 1'b1;
      end
    end else if (state_q == S_CHECK) begin
      if (rx_vld) begin
        hdr_ok_d = hdr_ok_q & ~hdr_bad;
        err_d    = err_q | rx_err;
        // a slot only counts as matched if all four target-IP bytes were seen and equal
        if (rx_a >= 38 && rx_a < 42)
          for (int k = 0; k < NUM_IP; k++)
            match_d[k] = ip_en[k] && rx_data == byte_of({16'h0, my_ip[32*k +: 32]}, 4, rx_a - 38) &&
                         (rx_a == 38 || match_q[k]);
        if (rx_a >= 6 && rx_a < 12) smac_d[8*(11-rx_a) +: 8] = rx_data;
        if (rx_a >= 28 && rx_a < 32) sip_d[8*(31-rx_a) +: 8] = rx_data;
        if (rx_last) begin
          if (rx_crc_ok && !err_d && hdr_ok_d && |match_d) begin
            state_d     = S_ARB;
            rep_d       = 1'b1;
            idx_d       = lowest(match_d);
            load        = 1'b1;
            count_arp_d = 1'b1;
            rx_cnt_d    = sat(rx_cnt_q);
          end else state_d = S_IDLE;
        end
      end
    end else if (state_q == S_ARB) begin
      if (tx_grant) state_d = S_SEND;
    end else if (state_q == S_SEND) begin
      if (tx_last) begin
        state_d = S_IDLE;
        if (rep_q) rep_cnt_d = sat(rep_cnt_q);
        else begin
          ann_cnt_d     = sat(ann_cnt_q);
          pend_d[idx_q] = 1'b0;
        end
      end else tx_data_d = tx_adv ? tx_byte(int'(tx_addr), rep_q, mac_sh_q, ip_sh_q, smac_q, sip_q) : tx_data_q;
    end
    if (load) begin
      mac_sh_d = my_hwaddr;
      ip_sh_d  = my_ip[32*int'(idx_d) +: 32];
    end
    if (announce_req || tmr_exp) pend_d = pend_d | ip_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rep_q       <= 1'b0;
      idx_q       <= '0;
      hdr_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      match_q     <= '0;
      smac_q      <= '0;
      sip_q       <= '0;
      mac_sh_q    <= '0;
      ip_sh_q     <= '0;
      tx_data_q   <= '0;
      count_arp_q <= 1'b0;
      rx_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      ann_cnt_q   <= '0;
      pend_q      <= '0;
      ip_en_q     <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rep_q       <= rep_d;
      idx_q       <= idx_d;
      hdr_ok_q    <= hdr_ok_d;
      err_q       <= err_d;
      match_q     <= match_d;
      smac_q      <= smac_d;
      sip_q       <= sip_d;
      mac_sh_q    <= mac_sh_d;
      ip_sh_q     <= ip_sh_d;
      tx_data_q   <= tx_data_d;
      count_arp_q <= count_arp_d;
      rx_cnt_q    <= rx_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      ann_cnt_q   <= ann_cnt_d;
      pend_q      <= pend_d;
      ip_en_q     <= ip_en;
      timer_q     <= timer_d;
    end
  end

  assign tx_req        = state_q == S_ARB;
  assign tx_count      = tx_req ? 11'(FRAME_LEN) : 11'd0;
  assign tx_data       = tx_data_q;
  assign count_arp     = count_arp_q;
  assign stat_rx_req   = rx_cnt_q;
  assign stat_tx_reply = rep_cnt_q;
  assign stat_tx_ann   = ann_cnt_q;
endmodule

// File: tb/tb_arp_engine.sv
// tb_arp_engine: directed checks of reply, reject, announce, timer, reset and saturation behaviour
module tb_arp_engine;
  localparam logic [47:0] MAC = 48'h021122334455;
  localparam logic [47:0] SHA = 48'h985AEBDD1C64;
  localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;

  logic         clk = 1'b0, reset = 1'b1;
  logic [47:0]  my_hwaddr = MAC;
  logic [127:0] my_ip = '0;
  logic [3:0]   ip_en = '0, ip_en3 = '0;
  logic         announce_req = 0, rx_vld = 0, rx_last = 0, rx_err = 0, rx_crc_ok = 0, rx_busy = 0;
  logic [10:0]  rx_addr = '0, tx_addr = '0;
  logic [7:0]   rx_data = '0;
  logic         tx_grant = 0, tx_adv = 0, tx_last = 0;
  logic         tx_req, tx_req2, tx_req3, count_arp, count_arp2, count_arp3;
  logic [10:0]  tx_count, tx_count2, tx_count3;
  logic [7:0]   tx_data, tx_data2, tx_data3;
  logic [15:0]  stat_rx_req, stat_tx_reply, stat_tx_ann, stat_rx_req3, stat_tx_reply3, stat_tx_ann3;
  logic [1:0]   stat_rx_req2, stat_tx_reply2, stat_tx_ann2;
  logic [7:0]   rx_buf [60];
  logic [7:0]   tx_buf [60];
  logic         use3 = 0, arp_seen, req_seen;
  int           cyc = 0, checks = 0, passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arp_engine dut (.clk(clk), .reset(reset), .my_hwaddr(my_hwaddr), .my_ip(my_ip), .ip_en(ip_en),
    .announce_req(announce_req), .rx_vld(rx_vld), .rx_last(rx_last), .rx_err(rx_err),
    .rx_crc_ok(rx_crc_ok), .rx_busy(rx_busy), .rx_addr(rx_addr), .rx_data(rx_data),
    .tx_req(tx_req), .tx_count(tx_count), .tx_grant(tx_grant), .tx_addr(tx_addr), .tx_adv(tx_adv),
    .tx_last(tx_last), .tx_data(tx_data), .count_arp(count_arp), .stat_rx_req(stat_rx_req),
    .stat_tx_reply(stat_tx_reply), .stat_tx_ann(stat_tx_ann));

  arp_engine #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .my_hwaddr(my_hwaddr), .my_ip(my_ip),
    .ip_en(ip_en), .announce_req(announce_req), .rx_vld(rx_vld), .rx_last(rx_last), .rx_err(rx_err),
    .rx_crc_ok(rx_crc_ok), .rx_busy(rx_busy), .rx_addr(rx_addr), .rx_data(rx_data),
    .tx_req(tx_req2), .tx_count(tx_count2), .tx_grant(tx_grant), .tx_addr(tx_addr), .tx_adv(tx_adv),
    .tx_last(tx_last), .tx_data(tx_data2), .count_arp(count_arp2), .stat_rx_req(stat_rx_req2),
    .stat_tx_reply(stat_tx_reply2), .stat_tx_ann(stat_tx_ann2));

  arp_engine #(.ANNOUNCE_PERIOD(100)) dut3 (.clk(clk), .reset(reset), .my_hwaddr(my_hwaddr),
    .my_ip(my_ip), .ip_en(ip_en3), .announce_req(announce_req), .rx_vld(rx_vld), .rx_last(rx_last),
    .rx_err(rx_err), .rx_crc_ok(rx_crc_ok), .rx_busy(rx_busy), .rx_addr(rx_addr), .rx_data(rx_data),
    .tx_req(tx_req3), .tx_count(tx_count3), .tx_grant(tx_grant), .tx_addr(tx_addr), .tx_adv(tx_adv),
    .tx_last(tx_last), .tx_data(tx_data3), .count_arp(count_arp3), .stat_rx_req(stat_rx_req3),
    .stat_tx_reply(stat_tx_reply3), .stat_tx_ann(stat_tx_ann3));

  function automatic logic [335:0] arp_frame(input logic [47:0] d0, input logic [47:0] smac,
      input logic [7:0] op, input logic [31:0] spa, input logic [47:0] tha, input logic [31:0] tpa);
    return {d0, smac, 72'h080600010800060400, op, smac, spa, tha, tpa};
  endfunction

  function automatic int frame_diff(input logic [335:0] e);
    logic [7:0] eb;
    for (int i = 0; i < 60; i++) begin
      eb = i < 42 ? e[335-8*i -: 8] : 8'h00;
      if (tx_buf[i] !== eb) return i;
    end
    return -1;
  endfunction

  task automatic build_req(input logic [47:0] dst, input logic [31:0] spa, input logic [31:0] tpa);
    logic [335:0] v;
    v = arp_frame(dst, SHA, 8'h01, spa, 48'h0, tpa);
    for (int i = 0; i < 60; i++) rx_buf[i] = i < 42 ? v[335-8*i -: 8] : 8'h00;
  endtask

  task automatic send_rx(input logic crc);
    rx_busy = 1;
    @(negedge clk);
    announce_req = 0;
    for (int i = 0; i < 60; i++) begin
      rx_vld = 1; rx_addr = 11'(i); rx_data = rx_buf[i];
      rx_last = i == 59; rx_crc_ok = crc && i == 59;
      @(negedge clk);
    end
    rx_vld = 0; rx_last = 0; rx_crc_ok = 0; rx_busy = 0;
    arp_seen = count_arp; req_seen = tx_req;
  endtask

  task automatic mac_grant(output logic ok, output logic [10:0] cnt, output int t);
    ok = 0; cnt = '0; t = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (use3 ? tx_req3 : tx_req) ok = 1;
      else @(negedge clk);
    end
    if (ok) begin
      cnt = use3 ? tx_count3 : tx_count; t = cyc;
      tx_grant = 1;
      @(negedge clk);
      tx_grant = 0;
    end
  endtask

  task automatic mac_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      tx_adv = 1; tx_addr = 11'(i);
      @(negedge clk);
      tx_buf[i] = use3 ? tx_data3 : tx_data;
    end
    tx_adv = 0;
  endtask

  task automatic mac_frame(output logic ok);
    logic [10:0] cnt;
    int t;
    mac_grant(ok, cnt, t);
    if (ok) begin
      mac_bytes(60);
      tx_last = 1;
      @(negedge clk);
      tx_last = 0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b want 0", tx_req); else passed++;
    checks++; if (tx_count !== 11'd0) $display("FAIL reset_tx_count: got %0d want 0", tx_count); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
    checks++; if (count_arp !== 1'b0) $display("FAIL reset_count_arp: got %b want 0", count_arp); else passed++;
    checks++; if ({stat_rx_req, stat_tx_reply, stat_tx_ann} !== 48'h0)
      $display("FAIL reset_stats: got %h want 0", {stat_rx_req, stat_tx_reply, stat_tx_ann}); else passed++;
  endtask

  task automatic test_reply;
    logic ok;
    logic [10:0] cnt;
    int t, d;
    my_ip = {32'h0, 32'h0, 32'hC0A80205, 32'h0}; ip_en = 4'b0010;
    build_req(BC, 32'hC0A80201, 32'hC0A80205);
    send_rx(1);
    checks++; if (arp_seen !== 1'b1) $display("FAIL reply_count_arp: got %b want 1", arp_seen); else passed++;
    checks++; if (req_seen !== 1'b1) $display("FAIL reply_arb_latency: got %b want 1", req_seen); else passed++;
    @(negedge clk);
    checks++; if (count_arp !== 1'b0) $display("FAIL reply_pulse_width: got %b want 0", count_arp); else passed++;
    mac_grant(ok, cnt, t);
    checks++; if (cnt !== 11'd60) $display("FAIL reply_tx_count: got %0d want 60", cnt); else passed++;
    checks++; if (tx_req !== 1'b0) $display("FAIL reply_req_drop: got %b want 0", tx_req); else passed++;
    mac_bytes(60);
    tx_last = 1; @(negedge clk); tx_last = 0;
    d = frame_diff(arp_frame(SHA, MAC, 8'h02, 32'hC0A80205, SHA, 32'hC0A80201));
    checks++; if (d != -1) $display("FAIL reply_frame: byte %0d got %h", d, tx_buf[d < 0 ? 0 : d]); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reply_data_idle: got %h want 00", tx_data); else passed++;
    checks++; if (stat_rx_req !== 16'd1 || stat_tx_reply !== 16'd1)
      $display("FAIL reply_stats: got rx=%0d rep=%0d want 1 1", stat_rx_req, stat_tx_reply); else passed++;
  endtask

  task automatic test_reject;
    send_rx(0);
    checks++; if ({arp_seen, req_seen} !== 2'b00) $display("FAIL reject_crc: got %b want 00", {arp_seen, req_seen}); else passed++;
    rx_buf[13] = 8'h00;
    send_rx(1);
    checks++; if ({arp_seen, req_seen} !== 2'b00) $display("FAIL reject_type: got %b want 00", {arp_seen, req_seen}); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (tx_req !== 1'b0) $display("FAIL reject_idle: got %b want 0", tx_req); else passed++;
    checks++; if (stat_rx_req !== 16'd1 || stat_tx_reply !== 16'd1)
      $display("FAIL reject_stats: got rx=%0d rep=%0d want 1 1", stat_rx_req, stat_tx_reply); else passed++;
  endtask

  task automatic test_slot_priority;
    logic ok;
    int d;
    my_ip = {32'h0, 32'h0A000001, 32'hC0A80205, 32'h0A000001}; ip_en = 4'b0101;
    build_req(MAC, 32'h0A000009, 32'h0A000001);
    send_rx(1);
    mac_frame(ok);
    d = ok ? frame_diff(arp_frame(SHA, MAC, 8'h02, 32'h0A000001, SHA, 32'h0A000009)) : 99;
    checks++; if (d != -1) $display("FAIL dup_slot_reply: first bad byte %0d", d); else passed++;
    ip_en = 4'b0000;
    send_rx(1);
    checks++; if ({arp_seen, req_seen} !== 2'b00) $display("FAIL disabled_slot: got %b want 00", {arp_seen, req_seen}); else passed++;
  endtask

  task automatic test_announce;
    logic ok;
    int d;
    my_ip = {32'h0, 32'h0A000003, 32'hC0A80205, 32'h0A000001}; ip_en = 4'b0101;
    announce_req = 1; @(negedge clk); announce_req = 0;
    mac_frame(ok);
    d = ok ? frame_diff(arp_frame(BC, MAC, 8'h01, 32'h0A000001, 48'h0, 32'h0A000001)) : 99;
    checks++; if (d != -1) $display("FAIL announce_slot0: first bad byte %0d", d); else passed++;
    mac_frame(ok);
    d = ok ? frame_diff(arp_frame(BC, MAC, 8'h01, 32'h0A000003, 48'h0, 32'h0A000003)) : 99;
    checks++; if (d != -1) $display("FAIL announce_slot2: first bad byte %0d", d); else passed++;
    checks++; if (stat_tx_ann !== 16'd2) $display("FAIL announce_count: got %0d want 2", stat_tx_ann); else passed++;
  endtask

  task automatic test_back_to_back;
    logic ok;
    int d;
    ip_en = 4'b0010;
    build_req(BC, 32'hC0A80201, 32'hC0A80205);
    announce_req = 1;
    send_rx(1);
    mac_frame(ok);
    d = ok ? frame_diff(arp_frame(SHA, MAC, 8'h02, 32'hC0A80205, SHA, 32'hC0A80201)) : 99;
    checks++; if (d != -1) $display("FAIL rx_first_reply: first bad byte %0d", d); else passed++;
    mac_frame(ok);
    d = ok ? frame_diff(arp_frame(BC, MAC, 8'h01, 32'hC0A80205, 48'h0, 32'hC0A80205)) : 99;
    checks++; if (d != -1) $display("FAIL rx_then_announce: first bad byte %0d", d); else passed++;
    checks++; if ({stat_rx_req, stat_tx_reply, stat_tx_ann} !== {16'd3, 16'd3, 16'd3})
      $display("FAIL b2b_stats: got %0d %0d %0d want 3 3 3", stat_rx_req, stat_tx_reply, stat_tx_ann); else passed++;
  endtask

  task automatic test_timer;
    logic ok1, ok2;
    logic [10:0] cnt;
    int t1, t2;
    use3 = 1; ip_en3 = 4'b0001;
    mac_grant(ok1, cnt, t1);
    if (ok1) begin mac_bytes(60); tx_last = 1; @(negedge clk); tx_last = 0; end
    checks++; if (!ok1 || tx_buf[0] !== 8'hFF || tx_buf[31] !== 8'h01)
      $display("FAIL timer_first: ok=%b b0=%h b31=%h want 1 ff 01", ok1, tx_buf[0], tx_buf[31]); else passed++;
    mac_grant(ok2, cnt, t2);
    if (ok2) begin mac_bytes(60); tx_last = 1; @(negedge clk); tx_last = 0; end
    checks++; if (!ok2 || t2 - t1 != 100) $display("FAIL timer_period: got %0d want 100", t2 - t1); else passed++;
    checks++; if (stat_tx_ann3 !== 16'd2) $display("FAIL timer_count: got %0d want 2", stat_tx_ann3); else passed++;
    ip_en3 = 4'b0000; use3 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_send;
    logic ok, seen;
    logic [10:0] cnt;
    int t;
    ip_en = 4'b0010;
    announce_req = 1; @(negedge clk); announce_req = 0;
    mac_grant(ok, cnt, t);
    if (ok) mac_bytes(10);
    checks++; if (!ok || tx_buf[9] !== 8'h33) $display("FAIL midsend_byte9: got %h want 33", tx_buf[9]); else passed++;
    #2 reset = 1;
    #1;
    checks++; if ({tx_req, tx_data} !== 9'h0) $display("FAIL async_reset_tx: got %h want 000", {tx_req, tx_data}); else passed++;
    checks++; if ({stat_rx_req, stat_tx_reply, stat_tx_ann} !== 48'h0)
      $display("FAIL async_reset_stats: got %h want 0", {stat_rx_req, stat_tx_reply, stat_tx_ann}); else passed++;
    @(negedge clk); reset = 0;
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= tx_req; end
    checks++; if (seen !== 1'b0) $display("FAIL reset_pend_clear: got tx_req %b want 0", seen); else passed++;
  endtask

  task automatic test_saturate;
    logic ok;
    int nok = 0;
    build_req(BC, 32'hC0A80201, 32'hC0A80205);
    repeat (5) begin send_rx(1); mac_frame(ok); nok += int'(ok); end
    checks++; if (nok != 5) $display("FAIL sat_frames: got %0d want 5", nok); else passed++;
    checks++; if (stat_rx_req !== 16'd5) $display("FAIL wide_rx_req: got %0d want 5", stat_rx_req); else passed++;
    checks++; if (stat_rx_req2 !== 2'd3 || stat_tx_reply2 !== 2'd3)
      $display("FAIL sat_hold: got rx=%0d rep=%0d want 3 3", stat_rx_req2, stat_tx_reply2); else passed++;
  endtask

  initial begin
    test_reset;
    test_reply;
    test_reject;
    test_slot_priority;
    test_announce;
    test_back_to_back;
    test_timer;
    test_reset_mid_send;
    test_saturate;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
